// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
//
// Parametrised synchronous up/down modulo counter with parallel load,
// wrap or saturate behaviour at the limits, and a combinational terminal
// count for cascading several stages into multi-digit chains.
//
// Parameters:
//   WIDTH    - counter register width in bits
//   MODULUS  - number of count states, q runs 0..MODULUS-1
//              (2 <= MODULUS <= 2**WIDTH)
//   SATURATE - 0: wrap around at the limits, 1: stick at the limits
//
// Ports:
//   ck     in   clock, rising edge
//   r      in   synchronous active-low reset
//   en     in   count enable (ignored while ld is high)
//   u      in   direction, 1 = up, 0 = down
//   ld     in   parallel load strobe
//   d      in   load value (clamped to MODULUS-1)
//   q      out  current count, registered
//   tc     out  terminal count, combinational; feed into next stage's en
//   evt    out  one-cycle pulse after a wrap or a blocked count
//   sticky out  latched evt, cleared by reset or load
// ---------------------------------------------------------------------------
module updown_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic             ck,
    input  logic             r,
    input  logic             en,
    input  logic             u,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             evt,
    output logic             sticky
);

    // Reject illegal moduli at elaboration time.
    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("updown_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_evt;
    logic             r_sticky;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_at_limit;
    logic [WIDTH-1:0] w_d_clamped;
    logic [WIDTH-1:0] w_q_next;
    logic             w_evt_next;
    logic             w_sticky_next;

    // Limit detection; the limit that matters depends on the direction.
    // Explicit compares are used even when MODULUS == 2**WIDTH, so the
    // full-range case behaves exactly like natural overflow.
    always_comb begin
        w_at_max   = (r_q == MAX);
        w_at_zero  = (r_q == '0);
        w_at_limit = u ? w_at_max : w_at_zero;
        // Loads never push q above MAX.
        w_d_clamped = (d > MAX) ? MAX : d;
    end

    // Next-state selection: ld > en > hold (reset handled in the flop).
    always_comb begin
        w_q_next      = r_q;
        w_evt_next    = 1'b0;
        w_sticky_next = r_sticky;
        if (ld) begin
            w_q_next      = w_d_clamped;
            w_evt_next    = 1'b0;
            w_sticky_next = 1'b0;
        end else if (en) begin
            if (w_at_limit) begin
                // Crossing a limit: wrap or hold, either way flag it.
                w_evt_next = 1'b1;
                if (SATURATE != 0) begin
                    w_q_next = r_q;
                end else begin
                    w_q_next = u ? '0 : MAX;
                end
            end else begin
                w_q_next = u ? (r_q + 1'b1) : (r_q - 1'b1);
            end
            w_sticky_next = r_sticky | w_evt_next;
        end
    end

    always_ff @(posedge ck) begin
        if (!r) begin
            r_q      <= '0;
            r_evt    <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_q      <= w_q_next;
            r_evt    <= w_evt_next;
            r_sticky <= w_sticky_next;
        end
    end

    // tc is combinational so a cascaded stage's en is valid in the same
    // cycle, letting every digit of a chain update on the same edge.
    assign tc     = en & ~ld & w_at_limit;
    assign q      = r_q;
    assign evt    = r_evt;
    assign sticky = r_sticky;

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: defaults (WIDTH=4, MODULUS=10, wrap)
    logic       a_r, a_en, a_u, a_ld;
    logic [3:0] a_d, a_q;
    logic       a_tc, a_evt, a_sticky;

    // Instance S: saturating decade counter
    logic       s_r, s_en, s_u, s_ld;
    logic [3:0] s_d, s_q;
    logic       s_tc, s_evt, s_sticky;

    // Instance N: full-range modulus 16 (natural overflow)
    logic       n_r, n_en, n_u, n_ld;
    logic [3:0] n_d, n_q;
    logic       n_tc, n_evt, n_sticky;

    // Chain: two default stages, stage1.en = stage0.tc
    logic       c_r, c_en, c_u, c_ld;
    logic [3:0] c_d, c0_q, c1_q;
    logic       c0_tc, c0_evt, c0_sticky, c1_tc, c1_evt, c1_sticky;

    updown_mod_counter u_a (
        .ck(ck), .r(a_r), .en(a_en), .u(a_u), .ld(a_ld), .d(a_d),
        .q(a_q), .tc(a_tc), .evt(a_evt), .sticky(a_sticky)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_s (
        .ck(ck), .r(s_r), .en(s_en), .u(s_u), .ld(s_ld), .d(s_d),
        .q(s_q), .tc(s_tc), .evt(s_evt), .sticky(s_sticky)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_n (
        .ck(ck), .r(n_r), .en(n_en), .u(n_u), .ld(n_ld), .d(n_d),
        .q(n_q), .tc(n_tc), .evt(n_evt), .sticky(n_sticky)
    );

    updown_mod_counter u_c0 (
        .ck(ck), .r(c_r), .en(c_en), .u(c_u), .ld(c_ld), .d(c_d),
        .q(c0_q), .tc(c0_tc), .evt(c0_evt), .sticky(c0_sticky)
    );

    updown_mod_counter u_c1 (
        .ck(ck), .r(c_r), .en(c0_tc), .u(c_u), .ld(c_ld), .d(c_d),
        .q(c1_q), .tc(c1_tc), .evt(c1_evt), .sticky(c1_sticky)
    );

    // Advance one edge; inputs and outputs settle 1 time unit after it.
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        a_r = 1'b0; a_en = 1'b1; a_u = 1'b1; a_ld = 1'b0; a_d = 4'd0;
        s_r = 1'b0; s_en = 1'b0; s_u = 1'b1; s_ld = 1'b0; s_d = 4'd0;
        n_r = 1'b0; n_en = 1'b0; n_u = 1'b1; n_ld = 1'b0; n_d = 4'd0;
        c_r = 1'b0; c_en = 1'b0; c_u = 1'b1; c_ld = 1'b0; c_d = 4'd0;
        tick();
        tick();
        n_vec++;
        if (a_q !== 4'd0) begin
            $display("FAIL reset_q: got %0d want 0", a_q); n_err++;
        end
        n_vec++;
        if (a_evt !== 1'b0 || a_sticky !== 1'b0) begin
            $display("FAIL reset_flags: got evt=%b sticky=%b want 0/0", a_evt, a_sticky); n_err++;
        end
        // en=1,u=1 with q=0 is not a terminal condition going up
        n_vec++;
        if (a_tc !== 1'b0) begin
            $display("FAIL reset_tc: got %b want 0", a_tc); n_err++;
        end
        a_r = 1'b1; s_r = 1'b1; n_r = 1'b1; c_r = 1'b1;
    endtask

    task automatic test_count_up();
        int  qe [12];
        int  ee [12];
        int  se [12];
        int  te [12];
        qe = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        ee = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        se = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        te = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        a_en = 1'b1; a_u = 1'b1; a_ld = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (a_tc !== te[i][0]) begin
                $display("FAIL up_tc[%0d]: got %b want %0d (q=%0d)", i, a_tc, te[i], a_q); n_err++;
            end
            tick();
            n_vec++;
            if (a_q !== qe[i][3:0] || a_evt !== ee[i][0] || a_sticky !== se[i][0]) begin
                $display("FAIL up_step[%0d]: got q=%0d evt=%b sticky=%b want q=%0d evt=%0d sticky=%0d",
                         i, a_q, a_evt, a_sticky, qe[i], ee[i], se[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_load_count_down();
        int qe [5];
        int ee [5];
        int te [5];
        qe = '{2, 1, 0, 9, 8};
        ee = '{0, 0, 0, 1, 0};
        te = '{0, 0, 0, 1, 0};
        a_en = 1'b0; a_ld = 1'b1; a_d = 4'd3;
        tick();
        n_vec++;
        if (a_q !== 4'd3 || a_evt !== 1'b0 || a_sticky !== 1'b0) begin
            $display("FAIL load3: got q=%0d evt=%b sticky=%b want 3/0/0", a_q, a_evt, a_sticky); n_err++;
        end
        a_ld = 1'b0; a_en = 1'b1; a_u = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (a_tc !== te[i][0]) begin
                $display("FAIL down_tc[%0d]: got %b want %0d (q=%0d)", i, a_tc, te[i], a_q); n_err++;
            end
            tick();
            n_vec++;
            if (a_q !== qe[i][3:0] || a_evt !== ee[i][0]) begin
                $display("FAIL down_step[%0d]: got q=%0d evt=%b want q=%0d evt=%0d",
                         i, a_q, a_evt, qe[i], ee[i]);
                n_err++;
            end
        end
        n_vec++;
        if (a_sticky !== 1'b1) begin
            $display("FAIL down_sticky: got %b want 1", a_sticky); n_err++;
        end
    endtask

    task automatic test_saturate();
        int qe [3];
        int ee [3];
        qe = '{9, 9, 9};
        ee = '{0, 1, 1};
        s_ld = 1'b1; s_en = 1'b0; s_d = 4'd8;
        tick();
        n_vec++;
        if (s_q !== 4'd8) begin
            $display("FAIL sat_load8: got %0d want 8", s_q); n_err++;
        end
        s_ld = 1'b0; s_en = 1'b1; s_u = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (s_q !== qe[i][3:0] || s_evt !== ee[i][0]) begin
                $display("FAIL sat_up[%0d]: got q=%0d evt=%b want q=%0d evt=%0d",
                         i, s_q, s_evt, qe[i], ee[i]);
                n_err++;
            end
        end
        n_vec++;
        if (s_tc !== 1'b1) begin
            $display("FAIL sat_tc_max: got %b want 1", s_tc); n_err++;
        end
        s_u = 1'b0;
        tick();
        n_vec++;
        if (s_q !== 4'd8 || s_evt !== 1'b0 || s_sticky !== 1'b1) begin
            $display("FAIL sat_down: got q=%0d evt=%b sticky=%b want 8/0/1", s_q, s_evt, s_sticky); n_err++;
        end
        // Blocked count at zero going down
        s_ld = 1'b1; s_d = 4'd0;
        tick();
        s_ld = 1'b0;
        tick();
        n_vec++;
        if (s_q !== 4'd0 || s_evt !== 1'b1 || s_sticky !== 1'b1) begin
            $display("FAIL sat_zero: got q=%0d evt=%b sticky=%b want 0/1/1", s_q, s_evt, s_sticky); n_err++;
        end
        s_en = 1'b0;
    endtask

    task automatic test_load_clamp();
        a_en = 1'b0; a_ld = 1'b1; a_d = 4'd14;
        tick();
        n_vec++;
        if (a_q !== 4'd9 || a_sticky !== 1'b0) begin
            $display("FAIL clamp14: got q=%0d sticky=%b want 9/0", a_q, a_sticky); n_err++;
        end
        a_ld = 1'b0; a_en = 1'b1; a_u = 1'b1;
        tick();
        n_vec++;
        if (a_q !== 4'd0 || a_evt !== 1'b1 || a_sticky !== 1'b1) begin
            $display("FAIL clamp_wrap: got q=%0d evt=%b sticky=%b want 0/1/1", a_q, a_evt, a_sticky); n_err++;
        end
        // ld with en: q==0 and u==0 would be terminal, but ld masks tc
        a_ld = 1'b1; a_en = 1'b1; a_u = 1'b0; a_d = 4'd2;
        #1;
        n_vec++;
        if (a_tc !== 1'b0) begin
            $display("FAIL ld_tc_mask: got %b want 0", a_tc); n_err++;
        end
        tick();
        n_vec++;
        if (a_q !== 4'd2 || a_evt !== 1'b0 || a_sticky !== 1'b0) begin
            $display("FAIL ld_over_en: got q=%0d evt=%b sticky=%b want 2/0/0", a_q, a_evt, a_sticky); n_err++;
        end
        a_ld = 1'b0; a_en = 1'b0;
        tick();
        n_vec++;
        if (a_q !== 4'd2 || a_evt !== 1'b0) begin
            $display("FAIL hold: got q=%0d evt=%b want 2/0", a_q, a_evt); n_err++;
        end
    endtask

    task automatic test_reset_mid_count();
        // Wrap once to set sticky, then count to 6
        a_ld = 1'b1; a_en = 1'b0; a_d = 4'd9;
        tick();
        a_ld = 1'b0; a_en = 1'b1; a_u = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_vec++;
        if (a_q !== 4'd6 || a_sticky !== 1'b1) begin
            $display("FAIL pre_reset: got q=%0d sticky=%b want 6/1", a_q, a_sticky); n_err++;
        end
        a_r = 1'b0; a_ld = 1'b1; a_d = 4'd5;
        tick();
        n_vec++;
        if (a_q !== 4'd0 || a_evt !== 1'b0 || a_sticky !== 1'b0) begin
            $display("FAIL mid_reset: got q=%0d evt=%b sticky=%b want 0/0/0", a_q, a_evt, a_sticky); n_err++;
        end
        a_r = 1'b1; a_ld = 1'b0;
        tick();
        n_vec++;
        if (a_q !== 4'd1) begin
            $display("FAIL resume: got %0d want 1", a_q); n_err++;
        end
        a_en = 1'b0;
    endtask

    task automatic test_full_range();
        n_ld = 1'b1; n_en = 1'b0; n_d = 4'd15;
        tick();
        n_vec++;
        if (n_q !== 4'd15) begin
            $display("FAIL full_load15: got %0d want 15", n_q); n_err++;
        end
        n_ld = 1'b0; n_en = 1'b1; n_u = 1'b1;
        #1;
        n_vec++;
        if (n_tc !== 1'b1) begin
            $display("FAIL full_tc: got %b want 1", n_tc); n_err++;
        end
        tick();
        n_vec++;
        if (n_q !== 4'd0 || n_evt !== 1'b1) begin
            $display("FAIL full_wrap_up: got q=%0d evt=%b want 0/1", n_q, n_evt); n_err++;
        end
        n_u = 1'b0;
        tick();
        n_vec++;
        if (n_q !== 4'd15 || n_evt !== 1'b1) begin
            $display("FAIL full_wrap_down: got q=%0d evt=%b want 15/1", n_q, n_evt); n_err++;
        end
        tick();
        n_vec++;
        if (n_q !== 4'd14 || n_evt !== 1'b0) begin
            $display("FAIL full_down: got q=%0d evt=%b want 14/0", n_q, n_evt); n_err++;
        end
        n_en = 1'b0;
    endtask

    task automatic test_cascade();
        int evt1_cnt;
        int evt1_edge;
        evt1_cnt  = 0;
        evt1_edge = -1;
        c_r = 1'b0;
        tick();
        c_r = 1'b1; c_en = 1'b1; c_u = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (c1_evt === 1'b1) begin
                evt1_cnt++;
                evt1_edge = i;
            end
            n_vec++;
            if (c1_q !== 4'((i % 100) / 10) || c0_q !== 4'(i % 10)) begin
                $display("FAIL chain[%0d]: got %0d%0d want %0d", i, c1_q, c0_q, i % 100); n_err++;
            end
        end
        n_vec++;
        if (evt1_cnt !== 1 || evt1_edge !== 100) begin
            $display("FAIL chain_evt1: got %0d pulses at edge %0d want 1 at edge 100", evt1_cnt, evt1_edge); n_err++;
        end
        c_en = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_count_up();
        test_load_count_down();
        test_saturate();
        test_load_clamp();
        test_reset_mid_count();
        test_full_range();
        test_cascade();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
